seatbelt_sensor_conditioner: RTL and testbench
==============================================

SEATBELT_SENSOR_CONDITIONER -- requirements
Module: seatbelt_sensor_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4, SHALL set the buckle-switch debounce length in clock cycles; legal range 2..255.
REQ-002 Parameter OCC_CYCLES, default 16, SHALL set the occupancy-sensor debounce length in clock cycles; legal range DEB_CYCLES..255.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be the reset, asynchronous and active-low.
REQ-005 Port raw_dbi, input, 1, SHALL be the asynchronous driver buckle switch; 1 = buckled.
REQ-006 Port raw_pbi, input, 1, SHALL be the asynchronous passenger buckle switch; 1 = buckled.
REQ-007 Port raw_occ, input, 1, SHALL be the asynchronous passenger-seat weight sensor; 1 = occupied.
REQ-008 Port DBI, output, 1, SHALL be the conditioned driver-belt-in signal for the seatbelt light logic.
REQ-009 Port PBI, output, 1, SHALL be the conditioned passenger-belt-in signal.
REQ-010 Port P, output, 1, SHALL be the conditioned passenger-present signal.
REQ-011 Port valid, output, 1, SHALL indicate that DBI/PBI/P reflect settled sensor state since reset.
REQ-012 Port change_stb, output, 1, SHALL pulse for one cycle when any of DBI/PBI/P changes while valid=1.

Function
REQ-013 Each raw input SHALL pass through its own two-flop synchronizer before any other logic.
REQ-014 Each channel SHALL hold a registered output and a mismatch counter sized for its own threshold (DEB_CYCLES for DBI/PBI, OCC_CYCLES for P).
REQ-015 On a cycle with synced input != channel output, the counter SHALL increment; when the counter is already N-1 it SHALL instead clear and the output SHALL toggle on that edge.
REQ-016 On any cycle with synced input == channel output, the counter SHALL clear to 0 (single-cycle agreement restarts the debounce).
REQ-017 Latency: raw input changed and held stable from edge k SHALL appear on the output at edge k+2+N, N being the channel threshold.
REQ-018 A raw pulse shorter than N cycles after synchronization SHALL produce no output change.
REQ-019 Channels SHALL be independent; simultaneous qualifying changes on several channels SHALL all update on their own due edges.
REQ-020 A startup counter SHALL count cycles after reset release; valid SHALL assert at edge OCC_CYCLES+3 after the first edge with reset_n=1 and stay high until the next reset.
REQ-021 change_stb SHALL be registered and be high in exactly the cycle in which the new output value first appears, if valid=1 in that cycle.
REQ-022 Changes occurring while valid=0 SHALL update outputs but SHALL NOT raise change_stb.
REQ-023 Two channels changing on the same edge SHALL produce a single one-cycle change_stb.
REQ-024 Counters SHALL saturate rather than wrap; no counter exceeds its threshold-1.

Reset
REQ-025 While reset_n=0, outputs SHALL be DBI=0, PBI=0, P=0, valid=0, change_stb=0 (fail-safe: light requested), asynchronously.
REQ-026 Reset SHALL clear all synchronizer flops, channel counters, and the startup counter.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count; after release the channel restarts from count 0.

Verification
REQ-028 Reset, raw_dbi=1 held from release, defaults -> DBI rises at edge 6 after release, valid at edge 19, change_stb stays 0.
REQ-029 After valid=1, raw_pbi 0->1 at edge k and held -> PBI=1 at edge k+6, change_stb=1 for that single cycle only.
REQ-030 After valid=1, raw_occ pulsed high 10 cycles then low -> P stays 0, change_stb stays 0.
REQ-031 raw_dbi toggled every 3 cycles for 40 cycles -> DBI never changes; counter repeatedly cleared.
REQ-032 raw_dbi and raw_pbi rise on same edge, valid=1 -> DBI and PBI update on the same edge, one change_stb pulse.
REQ-033 raw_occ=1 for 12 cycles, reset_n pulsed low, raw_occ held 1 -> P=0 during reset, P=1 at edge 18 after release.

Source files
------------

// File: rtl/seatbelt_sensor_conditioner.sv
// Seatbelt sensor conditioner: synchronizes and debounces buckle and occupancy
// inputs, then flags settled state and output changes for the light logic.

module seatbelt_debounce_chan #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic q,
   output logic flip
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          differ;

   assign differ = sync[1] != q;
   assign flip   = differ && (cnt == LAST);

   // A single cycle of agreement restarts the count from zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= '0;
         cnt  <= '0;
         q    <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (flip) begin
            cnt <= '0;
            q   <= ~q;
         end else if (differ) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

module seatbelt_sensor_conditioner #(
   parameter int DEB_CYCLES = 4,
   parameter int OCC_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_dbi,
   input  logic raw_pbi,
   input  logic raw_occ,
   output logic DBI,
   output logic PBI,
   output logic P,
   output logic valid,
   output logic change_stb
);

   localparam int VALID_AT = OCC_CYCLES + 3;
   localparam int SW = $clog2(VALID_AT + 1);
   localparam logic [SW-1:0] SETTLED = SW'(VALID_AT);

   logic          flip_dbi;
   logic          flip_pbi;
   logic          flip_occ;
   logic          any_flip;
   logic [SW-1:0] st_cnt;
   logic [SW-1:0] st_nxt;
   logic          valid_nxt;

   seatbelt_debounce_chan #(
      .N(DEB_CYCLES)
   ) u_dbi (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_dbi),
      .q      (DBI),
      .flip   (flip_dbi)
   );

   seatbelt_debounce_chan #(
      .N(DEB_CYCLES)
   ) u_pbi (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_pbi),
      .q      (PBI),
      .flip   (flip_pbi)
   );

   seatbelt_debounce_chan #(
      .N(OCC_CYCLES)
   ) u_occ (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_occ),
      .q      (P),
      .flip   (flip_occ)
   );

   assign any_flip = flip_dbi | flip_pbi | flip_occ;

   // Startup counter saturates once the slowest channel has had time to settle.
   always_comb begin
      st_nxt = st_cnt;
      if (st_cnt != SETTLED) begin
         st_nxt = st_cnt + SW'(1);
      end
   end

   assign valid_nxt = st_nxt == SETTLED;
   assign valid     = st_cnt == SETTLED;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_cnt     <= '0;
         change_stb <= 1'b0;
      end else begin
         st_cnt     <= st_nxt;
         change_stb <= any_flip && valid_nxt;
      end
   end

endmodule

// File: tb/tb_seatbelt_sensor_conditioner.sv
// Scoreboard bench for seatbelt_sensor_conditioner with directed vectors
// and hand-computed expected output snapshots and strobe cycles.

module tb_seatbelt_sensor_conditioner;

   typedef struct {
      int         cyc;
      logic [3:0] v;
      string      nm;
   } snap_t;

   logic clk;
   logic reset_n;
   logic raw_dbi;
   logic raw_pbi;
   logic raw_occ;
   logic DBI;
   logic PBI;
   logic P;
   logic valid;
   logic change_stb;

   int    cyc;
   int    checks;
   int    failures;
   int    k;
   int    r;
   snap_t exp_q[$];
   int    stb_q[$];

   seatbelt_sensor_conditioner dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw_dbi   (raw_dbi),
      .raw_pbi   (raw_pbi),
      .raw_occ   (raw_occ),
      .DBI       (DBI),
      .PBI       (PBI),
      .P         (P),
      .valid     (valid),
      .change_stb(change_stb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int c, input logic [3:0] v, input string nm);
      snap_t s;
      s.cyc = c;
      s.v   = v;
      s.nm  = nm;
      exp_q.push_back(s);
   endtask

   // Monitor: snapshots {DBI,PBI,P,valid} and every strobe the DUT raises.
   always @(negedge clk) begin
      logic [3:0] act;
      int         sc;
      act = {DBI, PBI, P, valid};
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         snap_t s;
         s = exp_q.pop_front();
         checks++;
         if (s.cyc != cyc || act !== s.v) begin
            failures++;
            $display("FAIL %s cyc=%0d want_cyc=%0d got=%b want=%b",
                     s.nm, cyc, s.cyc, act, s.v);
         end
      end
      if (change_stb === 1'b1) begin
         checks++;
         if (stb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_stb cyc=%0d got=1 want=0", cyc);
         end else begin
            sc = stb_q.pop_front();
            if (sc != cyc) begin
               failures++;
               $display("FAIL stb_cycle got=%0d want=%0d", cyc, sc);
            end
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      raw_dbi  = 1'b1;
      raw_pbi  = 1'b0;
      raw_occ  = 1'b0;

      // Reset with buckle already closed: DBI at +6, valid at +19, no strobe.
      step(2);
      expect_at(cyc + 1, 4'b0000, "in_reset");
      step(2);
      reset_n = 1'b1;
      r = cyc;
      expect_at(r + 5, 4'b0000, "dbi_before");
      expect_at(r + 6, 4'b1000, "dbi_rise");
      expect_at(r + 18, 4'b1000, "valid_before");
      expect_at(r + 19, 4'b1001, "valid_rise");
      step(25);

      // Passenger buckles after valid: PBI at k+6 with one strobe.
      k = cyc;
      raw_pbi = 1'b1;
      expect_at(k + 5, 4'b1001, "pbi_before");
      expect_at(k + 6, 4'b1101, "pbi_rise");
      expect_at(k + 7, 4'b1101, "pbi_hold");
      stb_q.push_back(k + 6);
      step(10);

      // Occupancy glitch of 10 cycles is shorter than 16.
      k = cyc;
      raw_occ = 1'b1;
      step(10);
      raw_occ = 1'b0;
      expect_at(k + 18, 4'b1101, "occ_glitch_18");
      expect_at(k + 30, 4'b1101, "occ_glitch_30");
      step(32);

      // Driver buckle chatter with 3-cycle runs never reaches 4.
      for (int i = 0; i < 14; i++) begin
         raw_dbi = ~raw_dbi;
         expect_at(cyc + 2, 4'b1101, "chatter");
         step(3);
      end
      step(8);
      expect_at(cyc + 1, 4'b1101, "chatter_end");
      step(2);

      // Both buckles release together, then close together.
      k = cyc;
      raw_dbi = 1'b0;
      raw_pbi = 1'b0;
      expect_at(k + 5, 4'b1101, "both_fall_before");
      expect_at(k + 6, 4'b0001, "both_fall");
      stb_q.push_back(k + 6);
      step(10);
      k = cyc;
      raw_dbi = 1'b1;
      raw_pbi = 1'b1;
      expect_at(k + 5, 4'b0001, "both_rise_before");
      expect_at(k + 6, 4'b1101, "both_rise");
      stb_q.push_back(k + 6);
      step(10);

      // Passenger sits down: P at k+18.
      k = cyc;
      raw_occ = 1'b1;
      expect_at(k + 17, 4'b1101, "occ_before");
      expect_at(k + 18, 4'b1111, "occ_rise");
      stb_q.push_back(k + 18);
      step(22);

      // Independent channels: DBI falls at +6, P falls at +18.
      k = cyc;
      raw_dbi = 1'b0;
      raw_occ = 1'b0;
      expect_at(k + 5, 4'b1111, "indep_before");
      expect_at(k + 6, 4'b0111, "indep_dbi");
      expect_at(k + 17, 4'b0111, "indep_mid");
      expect_at(k + 18, 4'b0101, "indep_occ");
      stb_q.push_back(k + 6);
      stb_q.push_back(k + 18);
      step(22);

      // Reset mid-debounce discards the partial occupancy count.
      k = cyc;
      raw_occ = 1'b1;
      expect_at(k + 11, 4'b0101, "occ_partial");
      expect_at(k + 12, 4'b0000, "async_reset");
      step(12);
      reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      r = cyc;
      expect_at(r + 5, 4'b0000, "rst2_pbi_before");
      expect_at(r + 6, 4'b0100, "rst2_pbi");
      expect_at(r + 17, 4'b0100, "rst2_occ_before");
      expect_at(r + 18, 4'b0110, "rst2_occ");
      expect_at(r + 19, 4'b0111, "rst2_valid");
      step(25);

      while (stb_q.size() > 0) begin
         int sc;
         sc = stb_q.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_stb got=none want_cyc=%0d", sc);
      end
      while (exp_q.size() > 0) begin
         snap_t s;
         s = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL unchecked_%s got=none want_cyc=%0d", s.nm, s.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
